// File: rtl/va_ovc_ctrl.sv
// va_ovc_ctrl: output-VC state controller in front of the VC allocator.
// Turns per-input-VC route requests into one-hot output-VC requests, consumes
// the allocator grants, and tracks owner, credits and life-cycle of every
// output VC until it can be handed out again.
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   req_valid[NV]      input VC i has a head flit needing an output VC
//   req_port[NV*N]     one-hot routed output port per input VC
//   reqVC_flat         one-hot output-VC request per input VC (combinational)
//   grantVC_flat       allocator grants, same layout as reqVC_flat
//   alloc_valid[NV]    one-cycle pulse: input VC i was allocated
//   alloc_ovc[NV*IW]   allocated output VC index per input VC
//   flit_sent[NV]      flit departed on output VC o (consumes a credit)
//   tail_sent[NV]      that departing flit is a tail
//   credit_ret[NV]     downstream freed one slot of output VC o
//   ovc_free[NV]       output VC o is idle
//   ovc_credit_ok[NV]  output VC o has at least one credit
//   err                sticky protocol error
module va_ovc_ctrl #(
  parameter int N     = 5,
  parameter int V     = 4,
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(N * V)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N*V-1:0]       req_valid,
  input  logic [N*V*N-1:0]     req_port,
  output logic [N*V*N*V-1:0]   reqVC_flat,
  input  logic [N*V*N*V-1:0]   grantVC_flat,
  output logic [N*V-1:0]       alloc_valid,
  output logic [N*V*IW-1:0]    alloc_ovc,
  input  logic [N*V-1:0]       flit_sent,
  input  logic [N*V-1:0]       tail_sent,
  input  logic [N*V-1:0]       credit_ret,
  output logic [N*V-1:0]       ovc_free,
  output logic [N*V-1:0]       ovc_credit_ok,
  output logic                 err
);

  localparam int NV = N * V;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    OVC_IDLE   = 2'd0,
    OVC_ACTIVE = 2'd1,
    OVC_DRAIN  = 2'd2
  } ovc_state_e;

  ovc_state_e        state_r [NV];
  ovc_state_e        state_s [NV];
  logic [CW-1:0]     cnt_r   [NV];
  logic [CW-1:0]     cnt_s   [NV];
  logic [IW-1:0]     owner_r [NV];
  logic [IW-1:0]     owner_s [NV];
  logic [NV-1:0]     hold_r, hold_s;
  logic [NV-1:0]     alloc_valid_r, alloc_valid_s;
  logic [NV*IW-1:0]  alloc_ovc_r, alloc_ovc_s;
  logic              err_r, err_s;

  logic [NV-1:0]     idle_s;
  logic [NV-1:0]     req_s [NV];
  logic [NV-1:0]     flit_ok_s, tail_ok_s, cred_ok_s, taken_s;
  logic              ev_err_s, grant_err_s;

  function automatic logic is_onehot(input logic [N-1:0] x);
    return (x != '0) && ((x & (x - N'(1))) == '0);
  endfunction

  // Lowest idle VC on the (one-hot) routed port, as a one-hot NV vector.
  function automatic logic [NV-1:0] pick_lowest_idle(input logic [N-1:0] port,
                                                     input logic [NV-1:0] idle);
    logic [NV-1:0] r;
    logic          found;
    r     = '0;
    found = 1'b0;
    for (int p = 0; p < N; p++) begin
      for (int v = 0; v < V; v++) begin
        if (port[p] && idle[p*V+v] && !found) begin
          r[p*V+v] = 1'b1;
          found    = 1'b1;
        end else begin
          r[p*V+v] = r[p*V+v];
        end
      end
    end
    return r;
  endfunction

  // Status decodes of the registered per-output-VC state.
  always_comb begin
    idle_s        = '0;
    ovc_credit_ok = '0;
    for (int o = 0; o < NV; o++) begin
      idle_s[o]        = (state_r[o] == OVC_IDLE);
      ovc_credit_ok[o] = (cnt_r[o] != '0);
    end
    ovc_free = idle_s;
  end

  // One-hot request generation; a holding input or a bad route requests nothing.
  always_comb begin
    reqVC_flat = '0;
    for (int i = 0; i < NV; i++) begin
      if (req_valid[i] && !hold_r[i] && is_onehot(req_port[i*N +: N])) begin
        req_s[i] = pick_lowest_idle(req_port[i*N +: N], idle_s);
      end else begin
        req_s[i] = '0;
      end
      reqVC_flat[i*NV +: NV] = req_s[i];
    end
  end

  // Qualify flit/tail/credit events; illegal ones are flagged and dropped.
  always_comb begin
    flit_ok_s = '0;
    tail_ok_s = '0;
    cred_ok_s = '0;
    ev_err_s  = 1'b0;
    for (int o = 0; o < NV; o++) begin
      if (flit_sent[o]) begin
        if (state_r[o] != OVC_ACTIVE) begin
          ev_err_s = 1'b1;
        end else if ((cnt_r[o] == '0) && !credit_ret[o]) begin
          ev_err_s = 1'b1;
        end else begin
          flit_ok_s[o] = 1'b1;
        end
      end else if (tail_sent[o]) begin
        // A tail is only meaningful together with its departing flit.
        ev_err_s = 1'b1;
      end else begin
        flit_ok_s[o] = 1'b0;
      end
      tail_ok_s[o] = flit_ok_s[o] & tail_sent[o];
      if (credit_ret[o]) begin
        // A credit is only legal at full when a real flit leaves in the same cycle.
        if ((cnt_r[o] == CNT_FULL) && !flit_ok_s[o]) begin
          ev_err_s = 1'b1;
        end else begin
          cred_ok_s[o] = 1'b1;
        end
      end else begin
        cred_ok_s[o] = 1'b0;
      end
    end
  end

  // Next-state: grants, credit counters, life-cycle transitions and error latch.
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    owner_s       = owner_r;
    hold_s        = hold_r;
    alloc_valid_s = '0;
    alloc_ovc_s   = alloc_ovc_r;
    taken_s       = '0;
    grant_err_s   = 1'b0;

    for (int i = 0; i < NV; i++) begin
      for (int o = 0; o < NV; o++) begin
        if (grantVC_flat[i*NV+o]) begin
          // taken_s catches a second grant to the same VC in one cycle.
          if (!req_s[i][o] || (state_r[o] != OVC_IDLE) || taken_s[o]) begin
            grant_err_s = 1'b1;
          end else begin
            taken_s[o]                 = 1'b1;
            state_s[o]                 = OVC_ACTIVE;
            owner_s[o]                 = IW'(i);
            hold_s[i]                  = 1'b1;
            alloc_valid_s[i]           = 1'b1;
            alloc_ovc_s[i*IW +: IW]    = IW'(o);
          end
        end else begin
          taken_s[o] = taken_s[o];
        end
      end
    end

    for (int o = 0; o < NV; o++) begin
      if (flit_ok_s[o] && !cred_ok_s[o]) begin
        cnt_s[o] = cnt_r[o] - CNT_ONE;
      end else if (cred_ok_s[o] && !flit_ok_s[o]) begin
        cnt_s[o] = cnt_r[o] + CNT_ONE;
      end else begin
        cnt_s[o] = cnt_r[o];
      end

      case (state_r[o])
        OVC_IDLE: begin
          // Leaving IDLE is handled by the grant loop above.
        end
        OVC_ACTIVE: begin
          if (tail_ok_s[o]) begin
            state_s[o] = (cnt_s[o] == CNT_FULL) ? OVC_IDLE : OVC_DRAIN;
            for (int i = 0; i < NV; i++) begin
              if (owner_r[o] == IW'(i)) begin
                hold_s[i] = 1'b0;
              end else begin
                hold_s[i] = hold_s[i];
              end
            end
          end else begin
            state_s[o] = OVC_ACTIVE;
          end
        end
        OVC_DRAIN: begin
          if (cnt_s[o] == CNT_FULL) begin
            state_s[o] = OVC_IDLE;
          end else begin
            state_s[o] = OVC_DRAIN;
          end
        end
        default: begin
          state_s[o] = OVC_IDLE;
        end
      endcase
    end

    err_s = err_r | grant_err_s | ev_err_s;
  end

  // State registers with synchronous reset; reset drops every allocation.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int o = 0; o < NV; o++) begin
        state_r[o] <= OVC_IDLE;
        cnt_r[o]   <= CNT_FULL;
        owner_r[o] <= '0;
      end
      hold_r        <= '0;
      alloc_valid_r <= '0;
      alloc_ovc_r   <= '0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      owner_r       <= owner_s;
      hold_r        <= hold_s;
      alloc_valid_r <= alloc_valid_s;
      alloc_ovc_r   <= alloc_ovc_s;
      err_r         <= err_s;
    end
  end

  assign alloc_valid = alloc_valid_r;
  assign alloc_ovc   = alloc_ovc_r;
  assign err         = err_r;

endmodule

// File: doc/va_ovc_ctrl.md
# va_ovc_ctrl

Output-VC state controller for the VC allocation stage. Sits in front of `va_main`: it turns per-input-VC route requests into the one-hot `N*V` request vectors `va_main` needs, consumes its grant vectors, and tracks every output VC (owner, credits, life-cycle) until the VC can be reused. It guarantees the one-hot request property that `va_main` depends on.

## Interface
Parameters:
- `N`, 5, router ports
- `V`, 4, VCs per port; VC index i = p*V+v for port p, VC v
- `DEPTH`, 4, downstream buffer slots per VC (initial credit count)
- `IW`, clog2(N*V) = 5, output-VC index width

Ports (clock and reset first):
- `clk`  in  1  clock
- `rstn`  in  1  reset, synchronous, active-low
- `req_valid`  in  N*V  input VC i has a head flit needing an output VC
- `req_port`  in  N*V*N  bits [i*N +: N]: one-hot output port routed for input VC i
- `reqVC_flat`  out  N*V*N*V  bits [i*N*V +: N*V]: one-hot request of input VC i, to `va_main`
- `grantVC_flat`  in  N*V*N*V  same layout; `va_main` grants
- `alloc_valid`  out  N*V  1-cycle pulse: input VC i was allocated
- `alloc_ovc`  out  N*V*IW  bits [i*IW +: IW]: allocated output VC index
- `flit_sent`  in  N*V  flit departed on output VC o (consumes a credit)
- `tail_sent`  in  N*V  departing flit is a tail; only valid with `flit_sent[o]`
- `credit_ret`  in  N*V  downstream freed one slot of output VC o
- `ovc_free`  out  N*V  output VC o is IDLE
- `ovc_credit_ok`  out  N*V  credit count of o > 0
- `err`  out  1  sticky protocol error

## Operation
- Per output VC o: state {IDLE, ACTIVE, DRAIN}, credit counter `cnt[o]` (width clog2(DEPTH+1)), owner index (IW bits).
- Per input VC i: `hold[i]` = i owns an ACTIVE output VC.
- Request generation (combinational from registered state): for input VC i with `req_valid[i]` and not `hold[i]`, take the port p in `req_port[i]`; select the lowest v with VC p*V+v IDLE; drive only that bit. No IDLE VC on p, `hold[i]`, or invalid `req_port` (not one-hot) -> all-zero request.
- Several inputs may target the same VC; `va_main` resolves it, losers re-request next cycle.
- Grant: bit o set in `grantVC_flat[i]` with matching request -> o: IDLE->ACTIVE, owner=i, `hold[i]`=1; `alloc_valid[i]`=1, `alloc_ovc[i]`=o next cycle.
- Credits: `cnt` -1 on `flit_sent`, +1 on `credit_ret`, unchanged if both.
- ACTIVE->DRAIN on `tail_sent[o]`; owner's `hold` cleared same edge. If updated `cnt`==DEPTH, go straight to IDLE.
- DRAIN->IDLE when updated `cnt` reaches DEPTH.
- `err` set (until reset) on: grant bit without matching request; grant to a non-IDLE VC; `flit_sent` with `cnt`==0 and no `credit_ret`; `credit_ret` with `cnt`==DEPTH and no `flit_sent`; `flit_sent`/`tail_sent` on a non-ACTIVE VC. Erroneous event ignored, counter saturates.

## Timing
- Reset (rstn=0 at edge): all VCs IDLE, `cnt`=DEPTH, owners 0, `hold`=0, `alloc_valid`=0, `alloc_ovc`=0, `err`=0; so `ovc_free` all 1, `ovc_credit_ok` all 1, `reqVC_flat` reflects inputs only. Reset mid-packet drops all allocations.
- `reqVC_flat` is combinational, same cycle as `req_valid`; `grantVC_flat` returns same cycle.
- Grant at edge T -> `alloc_valid` high in cycle T+1 for exactly one cycle; the VC is excluded from requests from T+1.
- `tail_sent` at T -> input VC may request again in T+1; output VC reusable in T+1 only if credits are full.
- `ovc_free`, `ovc_credit_ok` are registered-state decodes.

## Test plan
- Reset, input VC 0 (P0) requests port 2 -> `reqVC_flat[19:0]`=0x00100 (VC 8); grant -> `alloc_valid[0]`=1, `alloc_ovc[0]`=8 next cycle, `ovc_free[8]`=0.
- Inputs 0 and 5 both request port 2, grant to 5 only -> VC 8 owner 5; next cycle input 0 requests VC 9.
- VC 8 ACTIVE: 4 `flit_sent` no returns -> `ovc_credit_ok[8]`=0; tail on 4th -> DRAIN; 4 `credit_ret` -> IDLE on 4th.
- Simultaneous `flit_sent`+`credit_ret` at `cnt`=0 -> `cnt` stays 0, `err`=0.
- Port 3 VCs 12-15 all ACTIVE, new request for port 3 -> request zero until a VC returns IDLE.
- Grant to non-IDLE VC, or `credit_ret` at full -> `err`=1, held until `rstn`=0.
